// File: rtl/multadd_dot_seq_if.sv
// Handshake bundle between issue logic, the dot-product sequencer and its lane.
// Slave is the sequencer; master is the issue side plus the multadd lane.
interface multadd_dot_seq_if #(
   parameter int vdw_p       = 32,
   parameter int len_width_p = 8
);
   logic                   start_v_i;
   logic [len_width_p-1:0] start_len_i;
   logic                   ready_o;
   logic                   op_v_i;
   logic [vdw_p-1:0]       op_a_i;
   logic [vdw_p-1:0]       op_b_i;
   logic                   op_yumi_o;
   logic [vdw_p-1:0]       ma_a_o;
   logic [vdw_p-1:0]       ma_b_o;
   logic                   ma_use_fma_o;
   logic                   ma_fma_first_o;
   logic [vdw_p-1:0]       ma_data_i;
   logic                   ma_overflow_i;
   logic                   res_v_o;
   logic [vdw_p-1:0]       res_data_o;
   logic                   res_overflow_o;
   logic                   res_yumi_i;

   modport slave (
      input  start_v_i, start_len_i, op_v_i, op_a_i, op_b_i,
      input  ma_data_i, ma_overflow_i, res_yumi_i,
      output ready_o, op_yumi_o, ma_a_o, ma_b_o,
      output ma_use_fma_o, ma_fma_first_o,
      output res_v_o, res_data_o, res_overflow_o
   );

   modport master (
      output start_v_i, start_len_i, op_v_i, op_a_i, op_b_i,
      output ma_data_i, ma_overflow_i, res_yumi_i,
      input  ready_o, op_yumi_o, ma_a_o, ma_b_o,
      input  ma_use_fma_o, ma_fma_first_o,
      input  res_v_o, res_data_o, res_overflow_o
   );
endinterface

// File: rtl/multadd_dot_seq.sv
// Dot-product sequencer for one multadd lane: streams operand pairs into the
// lane's fused accumulate path and returns the final sum on a valid/yumi port.
module multadd_dot_seq #(
   parameter int vdw_p       = 32,
   parameter int len_width_p = 8
) (
   input logic               clk_i,
   input logic               reset_i,
   multadd_dot_seq_if.slave  io
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      DONE
   } state_t;

   state_t                 state, state_n;
   logic [len_width_p-1:0] cnt, cnt_n;
   logic [vdw_p-1:0]       res_data, res_data_n;
   logic                   res_ovf, res_ovf_n;
   logic                   first, first_n;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= IDLE;
         cnt      <= '0;
         res_data <= '0;
         res_ovf  <= 1'b0;
         first    <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         res_data <= res_data_n;
         res_ovf  <= res_ovf_n;
         first    <= first_n;
      end
   end

   always_comb begin
      state_n           = state;
      cnt_n             = cnt;
      res_data_n        = res_data;
      res_ovf_n         = res_ovf;
      first_n           = first;
      io.ready_o        = 1'b0;
      io.op_yumi_o      = 1'b0;
      io.res_v_o        = 1'b0;
      io.ma_a_o         = '0;
      io.ma_b_o         = '0;
      io.ma_use_fma_o   = 1'b1;
      io.ma_fma_first_o = 1'b1;
      case (state)
         IDLE: begin
            // fma_first held high keeps the unreset lane accumulator at 0
            io.ready_o = 1'b1;
            if (io.start_v_i) begin
               cnt_n     = io.start_len_i;
               res_ovf_n = 1'b0;
               if (io.start_len_i == '0) begin
                  res_data_n = '0;
                  state_n    = DONE;
               end else begin
                  first_n = 1'b1;
                  state_n = ACCUM;
               end
            end
         end
         ACCUM: begin
            io.op_yumi_o      = io.op_v_i;
            io.ma_fma_first_o = first;
            if (io.op_v_i) begin
               io.ma_a_o = io.op_a_i;
               io.ma_b_o = io.op_b_i;
               first_n   = 1'b0;
               cnt_n     = cnt - 1'b1;
               res_ovf_n = res_ovf | io.ma_overflow_i;
               if (cnt == len_width_p'(1)) state_n = DRAIN;
            end
         end
         DRAIN: begin
            // lane output now reflects the last product
            io.ma_fma_first_o = 1'b0;
            res_data_n        = io.ma_data_i;
            state_n           = DONE;
         end
         DONE: begin
            io.res_v_o = 1'b1;
            if (io.res_yumi_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign io.res_data_o     = res_data;
   assign io.res_overflow_o = res_ovf;

endmodule

// File: tb/tb_multadd_dot_seq.sv
// Scoreboarded bench for multadd_dot_seq with a behavioural multadd lane.
// Expected sums and overflow flags are computed from the driven operand pairs.
module tb_multadd_dot_seq;
   localparam int W = 32;
   localparam int L = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         o;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];
   logic [W-1:0] pa[8];
   logic [W-1:0] pb[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multadd_dot_seq_if #(.vdw_p(W), .len_width_p(L)) bus ();

   multadd_dot_seq #(.vdw_p(W), .len_width_p(L)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .io      (bus)
   );

   // multadd lane: registered accumulator, alu_op tied to 0
   logic [W-1:0]   acc = '0;
   logic [2*W-1:0] prod;
   logic [W:0]     sum;
   assign prod = {{W{1'b0}}, bus.ma_a_o} * {{W{1'b0}}, bus.ma_b_o};
   assign sum  = {1'b0, (bus.ma_fma_first_o ? {W{1'b0}} : acc)}
               + {1'b0, prod[W-1:0]};
   always @(posedge clk) acc <= sum[W-1:0];
   assign bus.ma_data_i     = acc;
   assign bus.ma_overflow_i = (|prod[2*W-1:W]) | sum[W];

   task automatic issue(input int len);
      exp_t e;
      logic [2*W-1:0] p;
      logic [W:0] s;
      e.d = '0;
      e.o = 1'b0;
      for (int i = 0; i < len; i++) begin
         p = {{W{1'b0}}, pa[i]} * {{W{1'b0}}, pb[i]};
         s = {1'b0, e.d} + {1'b0, p[W-1:0]};
         e.o = e.o | (|p[2*W-1:W]) | s[W];
         e.d = s[W-1:0];
      end
      exp_q.push_back(e);
      bus.start_v_i   = 1'b1;
      bus.start_len_i = L'(len);
      @(negedge clk);
      bus.start_v_i = 1'b0;
   endtask

   task automatic feed(input int idx, input int gap,
                       output int stray, output int miss, output int t);
      stray = 0;
      miss  = 0;
      repeat (gap) begin
         bus.op_v_i = 1'b0;
         #1;
         if (bus.op_yumi_o) stray++;
         @(negedge clk);
      end
      bus.op_v_i = 1'b1;
      bus.op_a_i = pa[idx];
      bus.op_b_i = pb[idx];
      #1;
      if (!bus.op_yumi_o) miss++;
      t = cyc;
      @(negedge clk);
      bus.op_v_i = 1'b0;
   endtask

   task automatic await_res(output int at, output logic [W-1:0] d,
                            output logic o);
      bit found;
      found = 0;
      at = -1;
      d  = '0;
      o  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.res_v_o) begin
            at = cyc;
            d  = bus.res_data_o;
            o  = bus.res_overflow_o;
            found = 1;
            break;
         end
         @(negedge clk);
      end
      if (found) @(negedge clk);
   endtask

   task automatic ack();
      bus.res_yumi_i = 1'b1;
      @(negedge clk);
      bus.res_yumi_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.op_v_i = 1'b1;
      bus.op_a_i = 32'd9;
      bus.op_b_i = 32'd9;
      @(negedge clk);
      #1;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
      total++; if (bus.res_v_o !== 1'b0) begin bad++; $display("FAIL reset_res_v got=%b want=0", bus.res_v_o); end
      total++; if (bus.op_yumi_o !== 1'b0) begin bad++; $display("FAIL reset_yumi got=%b want=0", bus.op_yumi_o); end
      total++; if (bus.ma_use_fma_o !== 1'b1) begin bad++; $display("FAIL reset_use_fma got=%b want=1", bus.ma_use_fma_o); end
      total++; if (bus.ma_fma_first_o !== 1'b1) begin bad++; $display("FAIL reset_fma_first got=%b want=1", bus.ma_fma_first_o); end
      total++; if (bus.ma_a_o !== '0 || bus.ma_b_o !== '0) begin bad++; $display("FAIL reset_ab got=%h/%h want=0/0", bus.ma_a_o, bus.ma_b_o); end
      total++; if (bus.res_data_o !== '0 || bus.res_overflow_o !== 1'b0) begin bad++; $display("FAIL reset_res got=%h/%b want=0/0", bus.res_data_o, bus.res_overflow_o); end
      @(negedge clk);
      reset = 1'b0;
      bus.op_v_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int s, m, t, ss, mm, at;
      logic [W-1:0] d;
      logic o;
      exp_t e;
      pa[0] = 1; pa[1] = 3; pa[2] = 5;
      pb[0] = 2; pb[1] = 4; pb[2] = 6;
      ss = 0; mm = 0; t = 0;
      issue(3);
      for (int i = 0; i < 3; i++) begin
         feed(i, 0, s, m, t);
         ss += s; mm += m;
      end
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (d !== e.d) begin bad++; $display("FAIL b2b_data got=%0d want=%0d", d, e.d); end
      total++; if (o !== e.o) begin bad++; $display("FAIL b2b_ovf got=%b want=%b", o, e.o); end
      total++; if (at !== t + 2) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", at, t + 2); end
      total++; if (mm !== 0) begin bad++; $display("FAIL b2b_yumi missed=%0d want=0", mm); end
      ack();
      #1;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%b want=1", bus.ready_o); end
      @(negedge clk);
   endtask

   task automatic test_bubbles();
      int s, m, t, ss, mm, at;
      int gaps[3];
      logic [W-1:0] d;
      logic o;
      exp_t e;
      gaps[0] = 0; gaps[1] = 1; gaps[2] = 3;
      pa[0] = 1; pa[1] = 3; pa[2] = 5;
      pb[0] = 2; pb[1] = 4; pb[2] = 6;
      ss = 0; mm = 0; t = 0;
      issue(3);
      for (int i = 0; i < 3; i++) begin
         feed(i, gaps[i], s, m, t);
         ss += s; mm += m;
      end
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (d !== e.d) begin bad++; $display("FAIL bub_data got=%0d want=%0d", d, e.d); end
      total++; if (ss !== 0) begin bad++; $display("FAIL bub_stray_yumi got=%0d want=0", ss); end
      total++; if (mm !== 0) begin bad++; $display("FAIL bub_yumi missed=%0d want=0", mm); end
      total++; if (at !== t + 2) begin bad++; $display("FAIL bub_latency got=%0d want=%0d", at, t + 2); end
      ack();
   endtask

   task automatic test_len_zero();
      int c0, at;
      logic [W-1:0] d;
      logic o;
      exp_t e;
      c0 = cyc;
      bus.op_v_i = 1'b1;
      bus.op_a_i = 32'd5;
      bus.op_b_i = 32'd5;
      issue(0);
      #1;
      total++; if (bus.op_yumi_o !== 1'b0) begin bad++; $display("FAIL len0_yumi got=%b want=0", bus.op_yumi_o); end
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (at !== c0 + 1) begin bad++; $display("FAIL len0_latency got=%0d want=%0d", at, c0 + 1); end
      total++; if (d !== e.d) begin bad++; $display("FAIL len0_data got=%h want=%h", d, e.d); end
      bus.op_v_i = 1'b0;
      ack();
   endtask

   task automatic test_wrap();
      int s, m, t, at;
      logic [W-1:0] d;
      logic o;
      exp_t e;
      pa[0] = 32'hFFFF_FFFF; pb[0] = 32'd2;
      pa[1] = 32'd1;         pb[1] = 32'd1;
      issue(2);
      feed(0, 0, s, m, t);
      feed(1, 0, s, m, t);
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (d !== e.d) begin bad++; $display("FAIL wrap_data got=%h want=%h", d, e.d); end
      total++; if (o !== e.o) begin bad++; $display("FAIL wrap_ovf got=%b want=%b", o, e.o); end
      ack();
   endtask

   task automatic test_hold();
      int s, m, t, at;
      logic [W-1:0] d;
      logic o;
      exp_t e;
      pa[0] = 2; pb[0] = 3;
      pa[1] = 4; pb[1] = 5;
      issue(2);
      feed(0, 0, s, m, t);
      feed(1, 0, s, m, t);
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (d !== e.d || o !== e.o) begin bad++; $display("FAIL hold_data got=%0d/%b want=%0d/%b", d, o, e.d, e.o); end
      for (int i = 0; i < 5; i++) begin
         bus.start_v_i   = 1'b1;
         bus.start_len_i = 8'd1;
         #1;
         total++; if (bus.res_v_o !== 1'b1 || bus.res_data_o !== e.d) begin bad++; $display("FAIL hold_stable cyc%0d got=%b/%0d want=1/%0d", i, bus.res_v_o, bus.res_data_o, e.d); end
         total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL hold_ready cyc%0d got=%b want=0", i, bus.ready_o); end
         @(negedge clk);
      end
      bus.start_v_i = 1'b0;
      ack();
      pa[0] = 7; pb[0] = 7;
      issue(1);
      feed(0, 0, s, m, t);
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (d !== e.d) begin bad++; $display("FAIL hold_next_data got=%0d want=%0d", d, e.d); end
      total++; if (o !== e.o) begin bad++; $display("FAIL hold_next_ovf got=%b want=%b", o, e.o); end
      ack();
   endtask

   task automatic test_reset_mid();
      int s, m, t, at;
      logic [W-1:0] d;
      logic o;
      exp_t e;
      pa[0] = 1; pa[1] = 2; pa[2] = 3; pa[3] = 4;
      pb[0] = 5; pb[1] = 6; pb[2] = 7; pb[3] = 8;
      issue(4);
      feed(0, 0, s, m, t);
      feed(1, 0, s, m, t);
      reset = 1'b1;
      #1;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", bus.ready_o); end
      total++; if (bus.res_v_o !== 1'b0) begin bad++; $display("FAIL rmid_res_v got=%b want=0", bus.res_v_o); end
      @(negedge clk);
      reset = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      pa[0] = 3; pb[0] = 3;
      issue(1);
      feed(0, 0, s, m, t);
      await_res(at, d, o);
      e = exp_q.pop_front();
      total++; if (d !== e.d) begin bad++; $display("FAIL rmid_next_data got=%0d want=%0d", d, e.d); end
      total++; if (at !== t + 2) begin bad++; $display("FAIL rmid_latency got=%0d want=%0d", at, t + 2); end
      ack();
   endtask

   initial begin
      bus.start_v_i   = 1'b0;
      bus.start_len_i = '0;
      bus.op_v_i      = 1'b0;
      bus.op_a_i      = '0;
      bus.op_b_i      = '0;
      bus.res_yumi_i  = 1'b0;
      test_reset();
      test_back_to_back();
      test_bubbles();
      test_len_zero();
      test_wrap();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
